// File: rtl/x_ramd64_fifo_ctrl.sv
// rtl/x_ramd64_fifo_ctrl.sv - 64-deep FIFO controller for a bank of 64x1 dual-port distributed RAM cells
//
// Purpose:
//   Drives the write enable and the shared 6-bit write/read addresses of WIDTH
//   64x1 dual-port RAM cells (one cell per data bit). Captures the bank's
//   asynchronous read port into a registered DOUT. Provides occupancy flags
//   and a 7-bit count. Depth is fixed at 64.
//
// Optional feature:
//   X_RAMD64_FIFO_ERR_FLAGS_EN adds the sticky OVERFLOW / UNDERFLOW outputs.
//
// Ports:
//   CLK          in   1      clock, rising edge
//   RST          in   1      synchronous reset, active-high
//   WR_EN        in   1      write request
//   DIN          in   WIDTH  write data
//   RD_EN        in   1      read request
//   RAM_DI       out  WIDTH  data to RAM bank I pins (= DIN)
//   WE           out  1      RAM bank write enable
//   WADR         out  6      RAM bank write address
//   RADR         out  6      RAM bank read address
//   RAM_DO       in   WIDTH  RAM bank O pins (asynchronous read of RADR)
//   DOUT         out  WIDTH  registered read data
//   DOUT_VALID   out  1      DOUT updated this cycle
//   FULL         out  1      COUNT == 64
//   EMPTY        out  1      COUNT == 0
//   ALMOST_FULL  out  1      COUNT >= AFULL_THRESH
//   ALMOST_EMPTY out  1      COUNT <= AEMPTY_THRESH
//   COUNT        out  7      occupancy, 0..64
//   OVERFLOW     out  1      sticky: write attempted while full   (macro only)
//   UNDERFLOW    out  1      sticky: read attempted while empty   (macro only)

module x_ramd64_fifo_ctrl #(
  parameter int WIDTH         = 8,
  parameter int AFULL_THRESH  = 60,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WR_EN,
  input  logic [WIDTH-1:0] DIN,
  input  logic             RD_EN,
  output logic [WIDTH-1:0] RAM_DI,
  output logic             WE,
  output logic [5:0]       WADR,
  output logic [5:0]       RADR,
  input  logic [WIDTH-1:0] RAM_DO,
  output logic [WIDTH-1:0] DOUT,
  output logic             DOUT_VALID,
  output logic             FULL,
  output logic             EMPTY,
  output logic             ALMOST_FULL,
  output logic             ALMOST_EMPTY,
`ifdef X_RAMD64_FIFO_ERR_FLAGS_EN
  output logic             OVERFLOW,
  output logic             UNDERFLOW,
`endif
  output logic [6:0]       COUNT
);

  localparam logic [6:0] DEPTH      = 7'd64;
  localparam logic [6:0] AFULL_LVL  = 7'(AFULL_THRESH);
  localparam logic [6:0] AEMPTY_LVL = 7'(AEMPTY_THRESH);

  logic [5:0]       wr_ptr;
  logic [5:0]       rd_ptr;
  logic [6:0]       count;
  logic [WIDTH-1:0] dout_q;
  logic             dout_valid_q;

  logic             full;
  logic             empty;
  logic             wr_acc;
  logic             rd_acc;

  // Flags decode from the registered count only, so a request accepted at
  // one edge is reflected in the flags from the following cycle.
  assign full  = (count == DEPTH);
  assign empty = (count == 7'd0);

  // Accept decisions use the start-of-cycle flags. When empty the read is
  // refused, which also guarantees read and write never hit the same cell.
  assign wr_acc = WR_EN & ~full;
  assign rd_acc = RD_EN & ~empty;

  // RAM bank interface. WE is gated by RST so no write lands in the bank
  // while the pointers are being cleared.
  assign RAM_DI = DIN;
  assign WE     = wr_acc & ~RST;
  assign WADR   = wr_ptr;
  assign RADR   = rd_ptr;

  assign DOUT         = dout_q;
  assign DOUT_VALID   = dout_valid_q;
  assign COUNT        = count;
  assign FULL         = full;
  assign EMPTY        = empty;
  assign ALMOST_FULL  = (count >= AFULL_LVL);
  assign ALMOST_EMPTY = (count <= AEMPTY_LVL);

  // Pointers wrap 63 -> 0 through natural 6-bit overflow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= 6'd0;
      rd_ptr <= 6'd0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 6'd1;
      if (rd_acc) rd_ptr <= rd_ptr + 6'd1;
    end
  end

  // Occupancy: simultaneous accepted read and write cancel out.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= 7'd0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 7'd1;
        2'b01:   count <= count - 7'd1;
        default: count <= count;
      endcase
    end
  end

  // Read data capture: the bank's asynchronous output at RADR is sampled at
  // the accepting edge, giving one cycle of read latency. DOUT holds
  // otherwise; DOUT_VALID is a single-cycle strobe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= rd_acc;
      if (rd_acc) dout_q <= RAM_DO;
    end
  end

`ifdef X_RAMD64_FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky error flags; only reset clears them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (WR_EN & full)  overflow_q  <= 1'b1;
      if (RD_EN & empty) underflow_q <= 1'b1;
    end
  end

  assign OVERFLOW  = overflow_q;
  assign UNDERFLOW = underflow_q;
`endif

endmodule

// File: tb/tb_x_ramd64_fifo_ctrl.sv
// tb/tb_x_ramd64_fifo_ctrl.sv - randomized self-checking bench for x_ramd64_fifo_ctrl against a queue model

module tb_x_ramd64_fifo_ctrl;

  localparam int WIDTH  = 8;
  localparam int AFULL  = 60;
  localparam int AEMPTY = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic [WIDTH-1:0] ram_di;
  logic             we;
  logic [5:0]       wadr;
  logic [5:0]       radr;
  logic [WIDTH-1:0] ram_do;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [6:0]       count;
`ifdef X_RAMD64_FIFO_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
`endif

  x_ramd64_fifo_ctrl #(
    .WIDTH(WIDTH), .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
  ) dut (
    .CLK(clk), .RST(rst), .WR_EN(wr_en), .DIN(din), .RD_EN(rd_en),
    .RAM_DI(ram_di), .WE(we), .WADR(wadr), .RADR(radr), .RAM_DO(ram_do),
    .DOUT(dout), .DOUT_VALID(dout_valid), .FULL(full), .EMPTY(empty),
    .ALMOST_FULL(almost_full), .ALMOST_EMPTY(almost_empty),
`ifdef X_RAMD64_FIFO_ERR_FLAGS_EN
    .OVERFLOW(overflow), .UNDERFLOW(underflow),
`endif
    .COUNT(count)
  );

  always #5 clk = ~clk;

  // Bank of WIDTH 64x1 cells: synchronous write, asynchronous read.
  logic [WIDTH-1:0] mem [64];
  always @(posedge clk) if (we) mem[wadr] <= ram_di;
  assign ram_do = mem[radr];

  // Reference model: a plain data queue plus running totals of accepted
  // writes/reads (their value modulo 64 is the expected RAM address).
  logic [WIDTH-1:0] q [$];
  int               n_wr;
  int               n_rd;
  logic [WIDTH-1:0] exp_dout;
  logic             exp_dv;
  logic             exp_ovf;
  logic             exp_udf;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    n_wr = 0; n_rd = 0;
    exp_dout = '0; exp_dv = 1'b0;
    exp_ovf = 1'b0; exp_udf = 1'b0;
  endtask

  task automatic check_regs();
    int sz;
    sz = q.size();
    check("count", 64'(count), 64'(sz));
    check("full", 64'(full), 64'(sz == 64));
    check("empty", 64'(empty), 64'(sz == 0));
    check("almost_full", 64'(almost_full), 64'(sz >= AFULL));
    check("almost_empty", 64'(almost_empty), 64'(sz <= AEMPTY));
    check("dout", 64'(dout), 64'(exp_dout));
    check("dout_valid", 64'(dout_valid), 64'(exp_dv));
`ifdef X_RAMD64_FIFO_ERR_FLAGS_EN
    check("overflow", 64'(overflow), 64'(exp_ovf));
    check("underflow", 64'(underflow), 64'(exp_udf));
`endif
  endtask

  // One clock cycle: drive at the falling edge, check combinational RAM-side
  // outputs before the rising edge, update the model, check registers after.
  task automatic step(input logic r, input logic w, input logic [WIDTH-1:0] d, input logic rd);
    bit wacc, racc;
    @(negedge clk);
    rst = r; wr_en = w; din = d; rd_en = rd;
    #1;
    wacc = w && (q.size() < 64);
    racc = rd && (q.size() > 0);
    check("we", 64'(we), 64'(wacc && !r));
    check("wadr", 64'(wadr), 64'(n_wr % 64));
    check("radr", 64'(radr), 64'(n_rd % 64));
    check("ram_di", 64'(ram_di), 64'(d));
    if (!r) begin
      if (w && q.size() == 64) exp_ovf = 1'b1;
      if (rd && q.size() == 0) exp_udf = 1'b1;
      exp_dv = racc;
      if (racc) begin
        exp_dout = q.pop_front();
        n_rd++;
      end
      if (wacc) begin
        q.push_back(d);
        n_wr++;
      end
    end
    @(posedge clk);
    #1;
    if (r) model_reset();
    check_regs();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst = 1'b1; wr_en = 1'b0; din = '0; rd_en = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    step(1'b1, 1'b0, '0, 1'b0);

    // Three writes then three reads.
    step(1'b0, 1'b1, 8'h11, 1'b0);
    step(1'b0, 1'b1, 8'h22, 1'b0);
    step(1'b0, 1'b1, 8'h33, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'($urandom), 1'b1);

    // Read while empty, then both while empty.
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'hA5, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Fill with 0x00..0x3F, then a 65th write.
    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    step(1'b0, 1'b1, 8'hEE, 1'b0);

    // Full: write and read together, only the read proceeds.
    step(1'b0, 1'b1, 8'hDD, 1'b1);

    // Drain down to one entry, then 70 write/read pairs across the wrap.
    while (q.size() > 1) step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 70; i++) step(1'b0, 1'b1, 8'($urandom), 1'b1);

    // Build to ten entries and reset mid-burst.
    while (q.size() < 10) step(1'b0, 1'b1, 8'($urandom), 1'b0);
    step(1'b1, 1'b1, 8'h5A, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Random traffic with phases biased toward fill and drain, rare resets.
    for (int ph = 0; ph < 12; ph++) begin
      int wp, rp;
      wp = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 15 : 50;
      rp = 100 - wp;
      for (int i = 0; i < 150; i++) begin
        step($urandom_range(0, 299) == 0,
             $urandom_range(0, 99) < wp,
             8'($urandom),
             $urandom_range(0, 99) < rp);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
